// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and codes for the load/store bridge
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } lsu_state_t;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_lane_fmt.sv
// rtl/lsu_lane_fmt.sv - byte-lane formatting and legality checks for sub-word accesses
module lsu_lane_fmt
    import lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{addr, 3'b000} +: 8];
    assign half_sel = rdata[{addr[1], 4'b0000} +: 16];

    always_comb begin
        be         = '0;
        store_data = '0;
        load_data  = '0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        // Unsigned variants share the size encoding in funct3[1:0], so byte enables come from it
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << addr;
            2'b01:   be = 4'b0011 << {addr[1], 1'b0};
            default: be = 4'b1111;
        endcase
        if (we) begin
            case (funct3)
                F3_B: store_data = {4{wdata[7:0]}};
                F3_H: begin
                    store_data = {2{wdata[15:0]}};
                    misaligned = addr[0];
                end
                F3_W: begin
                    store_data = wdata;
                    misaligned = |addr;
                end
                default: illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
                F3_BU: load_data = {24'd0, byte_sel};
                F3_H: begin
                    load_data  = {{16{half_sel[15]}}, half_sel};
                    misaligned = addr[0];
                end
                F3_HU: begin
                    load_data  = {16'd0, half_sel};
                    misaligned = addr[0];
                end
                F3_W: begin
                    load_data  = rdata;
                    misaligned = |addr;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/lsu_bridge.sv
// rtl/lsu_bridge.sv - core load/store port to request/grant/response data memory bridge
module lsu_bridge
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    lsu_state_t state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          timeout_hit;
    logic          we_q;
    logic [2:0]    funct3_q;
    logic [31:0]   addr_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic [1:0]    err_q;

    logic          fmt_we;
    logic [2:0]    fmt_funct3;
    logic [1:0]    fmt_addr;
    logic [3:0]    fmt_be;
    logic [31:0]   fmt_store;
    logic [31:0]   fmt_load;
    logic          fmt_misaligned;
    logic          fmt_illegal;

    // The formatter sees the live request in IDLE and the latched one afterwards
    assign fmt_we     = (state_q == IDLE) ? req_we           : we_q;
    assign fmt_funct3 = (state_q == IDLE) ? req_funct3       : funct3_q;
    assign fmt_addr   = (state_q == IDLE) ? req_addr[1:0]    : addr_q[1:0];

    lsu_lane_fmt u_lane_fmt (
        .we         (fmt_we),
        .funct3     (fmt_funct3),
        .addr       (fmt_addr),
        .wdata      (req_wdata),
        .rdata      (mem_rdata),
        .be         (fmt_be),
        .store_data (fmt_store),
        .load_data  (fmt_load),
        .misaligned (fmt_misaligned),
        .illegal    (fmt_illegal)
    );

    assign timeout_hit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_valid) state_d = (fmt_misaligned || fmt_illegal) ? DONE : ISSUE;
            // A grant on the final counted cycle cannot complete in time, so the timeout wins
            ISSUE: begin
                if (timeout_hit)  state_d = DONE;
                else if (mem_gnt) state_d = WAIT;
            end
            WAIT: if (mem_rvalid || timeout_hit) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= ERR_OK;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    we_q     <= req_we;
                    funct3_q <= req_funct3;
                    addr_q   <= req_addr;
                    be_q     <= fmt_be;
                    wdata_q  <= req_we ? fmt_store : 32'd0;
                    cnt_q    <= '0;
                    rdata_q  <= '0;
                    err_q    <= fmt_illegal    ? ERR_ILLEGAL  :
                                fmt_misaligned ? ERR_MISALIGN : ERR_OK;
                end
                ISSUE: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (timeout_hit) err_q <= ERR_TIMEOUT;
                end
                WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (mem_rvalid)       rdata_q <= we_q ? 32'd0 : fmt_load;
                    else if (timeout_hit) err_q   <= ERR_TIMEOUT;
                end
                default: ;
            endcase
        end
    end

    assign stall     = !reset && (((state_q == IDLE) && req_valid) ||
                                  (state_q == ISSUE) || (state_q == WAIT));
    assign rsp_valid = (state_q == DONE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_req   = (state_q == ISSUE);
    assign mem_we    = we_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_bridge.sv
// tb/tb_lsu_bridge.sv - scoreboard bench for lsu_bridge with a randomized memory responder
`timescale 1ns/1ps
module tb_lsu_bridge;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall, rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    lsu_bridge #(.TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  err;
        logic [31:0] rdata;
        int          lat;
        int          mreq;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          rsp_count = 0;
    int          drv_id = 0;
    int          drv_g, drv_r;
    logic [31:0] drv_rdata;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    logic        exp_we;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: access size, legality and lane math from the ISA rules, plus a latency budget
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int g, input int r,
                         input logic [31:0] rdata, output exp_t e,
                         output logic [3:0] be, output logic [31:0] wd);
        int          size, off;
        bit          ill, mis;
        logic [63:0] mask;
        logic [31:0] ld;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off  = int'(addr[1:0]);
        ill  = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        mis  = !ill && ((off % size) != 0);
        be   = 4'(((1 << size) - 1) << off);
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = wdata[8*(i % size) +: 8];
        mask = (64'd1 << (8 * size)) - 64'd1;
        ld   = (rdata >> (8 * off)) & mask[31:0];
        if (!f3[2] && size < 4 && ld[8*size-1]) ld = ld | ~mask[31:0];
        if (ill || mis) begin
            e.err = ill ? 2'b11 : 2'b01; e.rdata = 0; e.lat = 1; e.mreq = 0;
        end else if (g + r + 2 <= T) begin
            e.err = 2'b00; e.rdata = we ? 32'd0 : ld; e.lat = g + r + 3; e.mreq = g + 1;
        end else begin
            e.err = 2'b10; e.rdata = 0; e.lat = T + 1; e.mreq = (g + 1 < T) ? g + 1 : T;
        end
    endtask

    // Memory responder: grant after drv_g request cycles, respond drv_r cycles into WAIT
    initial begin
        int seen, phase, gcnt, rcnt;
        seen = 0; phase = 0; gcnt = 0; rcnt = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        forever begin
            @(negedge clk);
            mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
            if (seen != drv_id) begin
                seen = drv_id; phase = 0; gcnt = 0; rcnt = 0;
            end
            case (phase)
                0: if (mem_req) begin
                    check32("mem_addr", mem_addr, exp_addr);
                    check32("mem_we", 32'(mem_we), 32'(exp_we));
                    check32("mem_be", 32'(mem_be), 32'(exp_be));
                    if (exp_we) check32("mem_wdata", mem_wdata, exp_wdata);
                    if (gcnt == drv_g) begin mem_gnt = 1; phase = 1; end
                    else gcnt++;
                end
                1: if (rcnt == drv_r) begin
                    mem_rvalid = 1; mem_rdata = drv_rdata; phase = 2;
                end else rcnt++;
                default: ;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every rsp_valid
    initial begin
        int scnt, mcnt;
        exp_t e;
        scnt = 0; mcnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                scnt = 0; mcnt = 0;
            end else if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    check32("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check32("rsp_err", 32'(rsp_err), 32'(e.err));
                    check32("rsp_rdata", rsp_rdata, e.rdata);
                    check32("stall_at_rsp", 32'(stall), 32'd0);
                    check32("latency", 32'(scnt), 32'(e.lat));
                    check32("mem_req_cycles", 32'(mcnt), 32'(e.mreq));
                end
                rsp_count++;
                scnt = 0; mcnt = 0;
            end else begin
                if (stall) scnt++;
                if (mem_req) mcnt++;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check32({tag, "_stall"}, 32'(stall), 0);
        check32({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check32({tag, "_mem_req"}, 32'(mem_req), 0);
        check32({tag, "_rsp_rdata"}, rsp_rdata, 0);
        check32({tag, "_rsp_err"}, 32'(rsp_err), 0);
        check32({tag, "_mem_be"}, 32'(mem_be), 0);
        check32({tag, "_mem_we"}, 32'(mem_we), 0);
        check32({tag, "_mem_addr"}, mem_addr, 0);
        check32({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    task automatic arm(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int g, input int r,
                       input logic [31:0] rdata, output exp_t e);
        logic [3:0]  be;
        logic [31:0] wd;
        model(we, f3, addr, wdata, g, r, rdata, e, be, wd);
        drv_g = g; drv_r = r; drv_rdata = rdata;
        exp_addr = {addr[31:2], 2'b00}; exp_we = we; exp_be = be; exp_wdata = wd;
        drv_id++;
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    endtask

    // Called just after a rising edge; returns just after a rising edge with the core idle
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int g, input int r,
                           input logic [31:0] rdata);
        exp_t e;
        int   n0;
        n0 = rsp_count;
        arm(we, f3, addr, wdata, g, r, rdata, e);
        sbq.push_back(e);
        for (int i = 0; i < 40 && rsp_count == n0; i++) @(posedge clk);
        if (rsp_count == n0) begin
            checks++; errors++;
            $display("FAIL rsp_wait: no response within 40 cycles, expected one");
            sbq.delete();
        end
        #1 req_valid = 0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    endtask

    initial begin
        exp_t        e;
        logic [2:0]  f3;
        logic [2:0]  legal_f3 [5];
        legal_f3[0] = 3'b000; legal_f3[1] = 3'b001; legal_f3[2] = 3'b010;
        legal_f3[3] = 3'b100; legal_f3[4] = 3'b101;
        reset = 1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        drv_g = 0; drv_r = 0; drv_rdata = 0;
        exp_addr = 0; exp_we = 0; exp_be = 0; exp_wdata = 0;
        repeat (2) @(posedge clk);
        #1 req_valid = 1;
        #1 check_reset_outputs("init");
        req_valid = 0;
        @(posedge clk); #1 reset = 0;
        @(posedge clk); #1;

        run_txn(1, 3'b010, 32'h64, 32'h19, 0, 0, 32'h0);
        run_txn(0, 3'b000, 32'h63, 32'h0, 0, 0, 32'h80FF_1234);
        run_txn(0, 3'b100, 32'h63, 32'h0, 1, 0, 32'h80FF_1234);
        run_txn(1, 3'b001, 32'h62, 32'h0000_ABCD, 0, 1, 32'h0);
        run_txn(0, 3'b101, 32'h62, 32'h0, 0, 0, 32'hABCD_0000);
        run_txn(0, 3'b010, 32'h66, 32'h0, 0, 0, 32'h0);
        run_txn(0, 3'b011, 32'h60, 32'h0, 0, 0, 32'h0);
        run_txn(0, 3'b010, 32'h70, 32'h0, 20, 0, 32'h1234_5678);
        run_txn(0, 3'b010, 32'h74, 32'h0, 1, 1, 32'hCAFE_F00D);
        run_txn(0, 3'b010, 32'h78, 32'h0, 1, 2, 32'hCAFE_F00D);

        // Reset during WAIT: a store granted after two request cycles, response held back
        arm(1, 3'b010, 32'h200, 32'hDEAD_BEEF, 2, 6, 32'h0, e);
        repeat (4) @(posedge clk);
        #1 check32("in_wait_stall", 32'(stall), 1);
        reset = 1;
        #1 check_reset_outputs("wait_reset");
        @(posedge clk); #1 req_valid = 0;
        @(posedge clk); #1 reset = 0;
        repeat (10) @(posedge clk);
        #1 check32("post_reset_idle", 32'(stall), 0);
        run_txn(0, 3'b001, 32'h202, 32'h0, 0, 0, 32'h8001_0000);

        for (int n = 0; n < 80; n++) begin
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 4)];
            run_txn(1'($urandom), f3, $urandom, $urandom,
                    $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
        end

        repeat (3) @(posedge clk);
        if (sbq.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
